uart_loader: RTL

Boot-time program loader that receives an image over a UART serial line and writes it word-by-word into the write port of the instruction/data dual-port RAM. The CPU core is held in reset until the image is complete. It sits directly upstream of the RAM: its `w_en_o`/`w_addr_o`/`w_data_o` connect to the RAM's `w_en`/`w_addr_i`/`w_data_i`. The read port is untouched.

---
 rtl/uart_loader.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// uart_loader: UART boot loader writing a framed image into the RAM write port.
// Define UART_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte.
module uart_loader #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200,
   parameter int AW       = 12,
   parameter int DW       = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          uart_rx_i,
   output logic          w_en_o,
   output logic [AW-1:0] w_addr_o,
   output logic [DW-1:0] w_data_o,
   output logic          load_done_o,
   output logic          load_err_o,
   output logic          cpu_rst_n_o
);

   localparam int CPB  = CLK_FREQ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_START = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;
   localparam logic [1:0] R_STOP  = 2'd3;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LENLO = 3'd1;
   localparam logic [2:0] S_LENHI = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;
`ifdef UART_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CSUM  = 3'd4;
   localparam logic [2:0] S_FIN   = S_CSUM;
`else
   localparam logic [2:0] S_FIN   = S_DONE;
`endif

   logic          sy1_q, sy2_q, sy3_q;
   logic [1:0]    rs_q, rs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          rxv_q, rxv_d;
   logic          ferr_q, ferr_d;

   logic [2:0]    st_q, st_d;
   logic [15:0]   len_q, len_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [23:0]   asm_q, asm_d;
   logic [DW-1:0] wd_q, wd_d;
   logic          we_q, we_d;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   logic          n_big;
   logic          last;

   assign n_big = 32'({sh_q, len_q[7:0]}) > (32'd1 << AW);
   assign last  = addr_q == AW'(len_q - 16'd1);

   // Two-flop synchronizer plus a third stage for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sy1_q <= 1'b1;
         sy2_q <= 1'b1;
         sy3_q <= 1'b1;
      end else begin
         sy1_q <= uart_rx_i;
         sy2_q <= sy1_q;
         sy3_q <= sy2_q;
      end
   end

   // Receiver: start-bit glitch check, mid-bit data sampling, stop check.
   always_comb begin
      rs_d   = rs_q;
      cnt_d  = cnt_q + 1'b1;
      bit_d  = bit_q;
      sh_d   = sh_q;
      rxv_d  = 1'b0;
      ferr_d = 1'b0;
      unique case (rs_q)
         R_IDLE: begin
            cnt_d = CW'(1);
            if (sy3_q && !sy2_q) rs_d = R_START;
         end
         R_START: begin
            if (cnt_q == CW'(HALF - 1)) begin
               cnt_d = '0;
               bit_d = '0;
               rs_d  = sy2_q ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (cnt_q == CW'(CPB - 1)) begin
               cnt_d = '0;
               sh_d  = {sy2_q, sh_q[7:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) rs_d = R_STOP;
            end
         end
         R_STOP: begin
            if (cnt_q == CW'(CPB - 1)) begin
               rs_d   = R_IDLE;
               rxv_d  = sy2_q;
               ferr_d = !sy2_q;
            end
         end
         default: rs_d = R_IDLE;
      endcase
   end

   // Receiver state registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rs_q   <= R_IDLE;
         cnt_q  <= '0;
         bit_q  <= '0;
         sh_q   <= '0;
         rxv_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         rs_q   <= rs_d;
         cnt_q  <= cnt_d;
         bit_q  <= bit_d;
         sh_q   <= sh_d;
         rxv_q  <= rxv_d;
         ferr_q <= ferr_d;
      end
   end

   // Frame parser: sync, length, word assembly, optional checksum.
   always_comb begin
      st_d   = st_q;
      len_d  = len_q;
      addr_d = we_q ? addr_q + 1'b1 : addr_q;
      bcnt_d = bcnt_q;
      asm_d  = asm_q;
      wd_d   = wd_q;
      we_d   = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_d  = sum_q;
`endif
      unique case (st_q)
         S_IDLE, S_ERR: begin
            if (rxv_q && sh_q == 8'hA5) begin
               st_d   = S_LENLO;
               addr_d = '0;
               bcnt_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
               sum_d  = '0;
`endif
            end
         end
         S_LENLO: begin
            if (rxv_q) begin
               len_d[7:0] = sh_q;
               st_d       = S_LENHI;
            end
         end
         S_LENHI: begin
            if (rxv_q) begin
               len_d[15:8] = sh_q;
               if (n_big)
                  st_d = S_ERR;
               else if ({sh_q, len_q[7:0]} == 16'd0)
                  st_d = S_FIN;
               else
                  st_d = S_DATA;
            end
         end
         S_DATA: begin
            if (rxv_q) begin
               bcnt_d = bcnt_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
               sum_d  = sum_q + sh_q;
`endif
               unique case (bcnt_q)
                  2'd0: asm_d[7:0]   = sh_q;
                  2'd1: asm_d[15:8]  = sh_q;
                  2'd2: asm_d[23:16] = sh_q;
                  default: begin
                     we_d = 1'b1;
                     wd_d = {sh_q, asm_q};
                  end
               endcase
            end
            if (we_q && last) st_d = S_FIN;
         end
`ifdef UART_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (rxv_q) st_d = (sh_q == sum_q) ? S_DONE : S_ERR;
         end
`endif
         S_DONE: st_d = S_DONE;
         default: st_d = S_IDLE;
      endcase
      if (ferr_q && st_q != S_DONE) st_d = S_ERR;
   end

   // Parser state and RAM write-port registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q   <= S_IDLE;
         len_q  <= '0;
         addr_q <= '0;
         bcnt_q <= '0;
         asm_q  <= '0;
         wd_q   <= '0;
         we_q   <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q  <= '0;
`endif
      end else begin
         st_q   <= st_d;
         len_q  <= len_d;
         addr_q <= addr_d;
         bcnt_q <= bcnt_d;
         asm_q  <= asm_d;
         wd_q   <= wd_d;
         we_q   <= we_d;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q  <= sum_d;
`endif
      end
   end

   assign w_en_o      = we_q;
   assign w_addr_o    = addr_q;
   assign w_data_o    = wd_q;
   assign load_done_o = st_q == S_DONE;
   assign cpu_rst_n_o = st_q == S_DONE;
   assign load_err_o  = st_q == S_ERR;

endmodule
